// File: rtl/traffic_pkg.sv
// Shared encodings, fault codes and FSM states for the lamp monitor.
// Also holds the per-road transition legality helper.
package traffic_pkg;

  typedef logic [2:0] light_t;

  localparam light_t RED   = 3'b100;
  localparam light_t AMBER = 3'b010;
  localparam light_t GREEN = 3'b001;
  localparam light_t DARK  = 3'b000;

  localparam logic [2:0] F_NONE     = 3'd0;
  localparam logic [2:0] F_ONEHOT   = 3'd1;
  localparam logic [2:0] F_CONFLICT = 3'd2;
  localparam logic [2:0] F_SEQ      = 3'd3;
  localparam logic [2:0] F_ALLRED   = 3'd4;

  typedef enum logic [1:0] {
    NORMAL,
    FAULT,
    RECOVER
  } state_t;

  function automatic logic is_onehot(light_t l);
    return (l == RED) || (l == AMBER) || (l == GREEN);
  endfunction

  // Previous value that is not a legal code is never judged.
  function automatic logic step_ok(light_t p, light_t c);
    logic ok;
    ok = 1'b1;
    unique case (p)
      GREEN:   ok = (c == GREEN) || (c == AMBER);
      AMBER:   ok = (c == AMBER) || (c == RED);
      RED:     ok = (c == RED) || (c == GREEN);
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lamp_blinker.sv
// Amber flash phase generator, BLINK_HALF cycles per half-period.
// Ports: clk, reset, restart (force ON), enable (advance), phase_on.
module lamp_blinker #(
  parameter int BLINK_HALF = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  input  logic enable,
  output logic phase_on
);

  localparam int CW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;
  logic          wrap;

  assign wrap = (cnt_q == CW'(BLINK_HALF - 1));

  // phase_on is the phase of the lamp word loaded at the coming edge.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (restart) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (enable) begin
      if (wrap) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign phase_on = phase_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/traffic_lamp_monitor.sv
// Safety monitor between traffic controller and lamps.
// Ports: light_A/B in, lamp_A/B out, clear_fault, fault, fault_code, fault_count.
module traffic_lamp_monitor
  import traffic_pkg::*;
#(
  parameter int BLINK_HALF  = 1,
  parameter int MIN_ALLRED  = 2,
  parameter int RECOVER_CYC = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] light_A,
  input  logic [2:0] light_B,
  input  logic       clear_fault,
  output logic [2:0] lamp_A,
  output logic [2:0] lamp_B,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [7:0] fault_count
);

  localparam int AW = $clog2(MIN_ALLRED + 1);
  localparam int RW = $clog2(RECOVER_CYC + 1);
  localparam logic [AW-1:0] ALLRED_MAX = AW'(MIN_ALLRED);
  localparam logic [RW-1:0] REC_LAST   = RW'(RECOVER_CYC - 1);

  state_t        state_q, state_d;
  light_t        prev_a_q, prev_b_q;
  logic [AW-1:0] allred_q, allred_d;
  logic [RW-1:0] rec_q, rec_d;
  logic [2:0]    code_q, code_d;
  logic [7:0]    cnt_q, cnt_d;
  light_t        lamp_a_q, lamp_a_d;
  light_t        lamp_b_q, lamp_b_d;

  logic       both_red;
  logic       r2g;
  logic [2:0] det;
  logic       restart;
  logic       blink_on;

  assign both_red = (light_A == RED) && (light_B == RED);
  assign r2g = ((prev_a_q == RED) && (light_A == GREEN))
            || ((prev_b_q == RED) && (light_B == GREEN));

  always_comb begin
    det = F_NONE;
    if (!is_onehot(light_A) || !is_onehot(light_B))
      det = F_ONEHOT;
    else if ((light_A != RED) && (light_B != RED))
      det = F_CONFLICT;
    else if (!step_ok(prev_a_q, light_A) || !step_ok(prev_b_q, light_B))
      det = F_SEQ;
    else if (r2g && (allred_q < ALLRED_MAX))
      det = F_ALLRED;
  end

  always_comb begin
    if (!both_red)
      allred_d = '0;
    else if (allred_q == ALLRED_MAX)
      allred_d = allred_q;
    else
      allred_d = allred_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    rec_d   = rec_q;
    unique case (state_q)
      NORMAL: begin
        if (det != F_NONE) begin
          state_d = FAULT;
          code_d  = det;
          if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        end
      end
      FAULT: begin
        if (clear_fault && both_red) begin
          state_d = RECOVER;
          rec_d   = '0;
        end
      end
      RECOVER: begin
        if (both_red && (det == F_NONE)) begin
          if (rec_q == REC_LAST) begin
            state_d = NORMAL;
            code_d  = F_NONE;
          end else begin
            rec_d = rec_q + 1'b1;
          end
        end else begin
          state_d = FAULT;
        end
      end
      default: state_d = NORMAL;
    endcase
  end

  assign restart = (state_d == FAULT) && (state_q != FAULT);

  lamp_blinker #(
    .BLINK_HALF(BLINK_HALF)
  ) u_blink (
    .clk     (clk),
    .reset   (reset),
    .restart (restart),
    .enable  (state_q == FAULT),
    .phase_on(blink_on)
  );

  // Lamps follow the state being entered, so a violating input
  // is never passed through.
  always_comb begin
    lamp_a_d = RED;
    lamp_b_d = RED;
    unique case (state_d)
      NORMAL: begin
        lamp_a_d = light_A;
        lamp_b_d = light_B;
      end
      FAULT: begin
        lamp_a_d = blink_on ? AMBER : DARK;
        lamp_b_d = blink_on ? AMBER : DARK;
      end
      RECOVER: begin
        lamp_a_d = RED;
        lamp_b_d = RED;
      end
      default: begin
        lamp_a_d = RED;
        lamp_b_d = RED;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= NORMAL;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_a_q <= RED;
      prev_b_q <= RED;
      allred_q <= ALLRED_MAX;
      rec_q    <= '0;
      code_q   <= F_NONE;
      cnt_q    <= '0;
      lamp_a_q <= RED;
      lamp_b_q <= RED;
    end else begin
      prev_a_q <= light_A;
      prev_b_q <= light_B;
      allred_q <= allred_d;
      rec_q    <= rec_d;
      code_q   <= code_d;
      cnt_q    <= cnt_d;
      lamp_a_q <= lamp_a_d;
      lamp_b_q <= lamp_b_d;
    end
  end

  assign lamp_A      = lamp_a_q;
  assign lamp_B      = lamp_b_q;
  assign fault       = (state_q != NORMAL);
  assign fault_code  = code_q;
  assign fault_count = cnt_q;

endmodule

// File: tb/tb_traffic_lamp_monitor.sv
// Bench for traffic_lamp_monitor: vector table plus scoreboard queue.
// Expected values are written out by hand from the intended behaviour.
module tb_traffic_lamp_monitor;
  import traffic_pkg::*;

  typedef struct {
    logic [2:0] la;
    logic [2:0] lb;
    logic       clr;
    logic [2:0] ea;
    logic [2:0] eb;
    logic       ef;
    logic [2:0] ec;
    logic [7:0] en;
  } vec_t;

  typedef struct {
    int         id;
    logic [2:0] ea;
    logic [2:0] eb;
    logic       ef;
    logic [2:0] ec;
    logic [7:0] en;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] light_A, light_B;
  logic       clear_fault;
  logic [2:0] lamp_A, lamp_B;
  logic       fault;
  logic [2:0] fault_code;
  logic [7:0] fault_count;

  int n_run  = 0;
  int n_fail = 0;
  exp_t sb[$];
  vec_t tbl[25];

  always #5 clk = ~clk;

  traffic_lamp_monitor #(
    .BLINK_HALF (1),
    .MIN_ALLRED (2),
    .RECOVER_CYC(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .light_A    (light_A),
    .light_B    (light_B),
    .clear_fault(clear_fault),
    .lamp_A     (lamp_A),
    .lamp_B     (lamp_B),
    .fault      (fault),
    .fault_code (fault_code),
    .fault_count(fault_count)
  );

  function automatic vec_t V(logic [2:0] la, logic [2:0] lb, logic clr,
                             logic [2:0] ea, logic [2:0] eb, logic ef,
                             logic [2:0] ec, logic [7:0] en);
    vec_t v;
    v.la = la; v.lb = lb; v.clr = clr;
    v.ea = ea; v.eb = eb; v.ef = ef; v.ec = ec; v.en = en;
    return v;
  endfunction

  task automatic check();
    exp_t e;
    n_run++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got output with no expectation");
      return;
    end
    e = sb.pop_front();
    if ({lamp_A, lamp_B, fault, fault_code, fault_count} !==
        {e.ea, e.eb, e.ef, e.ec, e.en}) begin
      n_fail++;
      $display("FAIL vec%0d: got A=%b B=%b f=%b code=%0d cnt=%0d, want A=%b B=%b f=%b code=%0d cnt=%0d",
               e.id, lamp_A, lamp_B, fault, fault_code, fault_count,
               e.ea, e.eb, e.ef, e.ec, e.en);
    end
  endtask

  task automatic drive(input int id, input logic rst, input vec_t v);
    exp_t e;
    reset       = rst;
    light_A     = v.la;
    light_B     = v.lb;
    clear_fault = v.clr;
    e.id = id; e.ea = v.ea; e.eb = v.eb;
    e.ef = v.ef; e.ec = v.ec; e.en = v.en;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check();
  endtask

  initial begin
    logic [2:0] la;

    // State before tbl[0]: NORMAL, prev R/R, all-red count saturated.
    tbl[0]  = V(GREEN, GREEN, 0, AMBER, AMBER, 1, F_CONFLICT, 1);
    tbl[1]  = V(RED,   RED,   0, DARK,  DARK,  1, F_CONFLICT, 1);
    tbl[2]  = V(RED,   RED,   0, AMBER, AMBER, 1, F_CONFLICT, 1);
    tbl[3]  = V(RED,   RED,   0, DARK,  DARK,  1, F_CONFLICT, 1);
    tbl[4]  = V(RED,   RED,   1, RED,   RED,   1, F_CONFLICT, 1);
    tbl[5]  = V(RED,   RED,   0, RED,   RED,   1, F_CONFLICT, 1);
    tbl[6]  = V(RED,   RED,   0, RED,   RED,   0, F_NONE,     1);
    tbl[7]  = V(GREEN, RED,   0, GREEN, RED,   0, F_NONE,     1);
    tbl[8]  = V(RED,   RED,   0, AMBER, AMBER, 1, F_SEQ,      2);
    tbl[9]  = V(RED,   RED,   0, DARK,  DARK,  1, F_SEQ,      2);
    tbl[10] = V(RED,   RED,   1, RED,   RED,   1, F_SEQ,      2);
    tbl[11] = V(RED,   GREEN, 0, AMBER, AMBER, 1, F_SEQ,      2);
    tbl[12] = V(RED,   RED,   0, DARK,  DARK,  1, F_SEQ,      2);
    tbl[13] = V(RED,   RED,   1, RED,   RED,   1, F_SEQ,      2);
    tbl[14] = V(RED,   RED,   0, RED,   RED,   1, F_SEQ,      2);
    tbl[15] = V(RED,   RED,   0, RED,   RED,   0, F_NONE,     2);
    tbl[16] = V(GREEN, RED,   0, GREEN, RED,   0, F_NONE,     2);
    tbl[17] = V(AMBER, RED,   0, AMBER, RED,   0, F_NONE,     2);
    tbl[18] = V(RED,   RED,   0, RED,   RED,   0, F_NONE,     2);
    tbl[19] = V(RED,   GREEN, 0, AMBER, AMBER, 1, F_ALLRED,   3);
    tbl[20] = V(RED,   RED,   1, RED,   RED,   1, F_ALLRED,   3);
    tbl[21] = V(RED,   RED,   0, RED,   RED,   1, F_ALLRED,   3);
    tbl[22] = V(3'b110, RED,  0, AMBER, AMBER, 1, F_ALLRED,   3);
    tbl[23] = V(RED,   GREEN, 1, DARK,  DARK,  1, F_ALLRED,   3);
    tbl[24] = V(GREEN, RED,   0, AMBER, AMBER, 1, F_ALLRED,   3);

    reset = 1'b1; light_A = RED; light_B = RED; clear_fault = 1'b0;

    drive(0, 1'b1, V(RED, RED, 0, RED, RED, 0, F_NONE, 0));
    drive(1, 1'b1, V(GREEN, GREEN, 1, RED, RED, 0, F_NONE, 0));

    // Nominal controller cycle: A green 7, amber 2, red 2; B red.
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 11; i++) begin
        la = (i < 7) ? GREEN : (i < 9) ? AMBER : RED;
        drive(100 + c * 11 + i, 1'b0,
              V(la, RED, 0, la, RED, 0, F_NONE, 0));
      end
    end

    for (int i = 0; i < 25; i++) drive(200 + i, 1'b0, tbl[i]);

    // Reset mid-FAULT, then an immediate green must be accepted.
    drive(300, 1'b1, V(AMBER, RED, 0, RED, RED, 0, F_NONE, 0));
    drive(301, 1'b0, V(GREEN, RED, 0, GREEN, RED, 0, F_NONE, 0));
    drive(302, 1'b0, V(AMBER, RED, 0, AMBER, RED, 0, F_NONE, 0));
    drive(303, 1'b0, V(DARK, RED, 0, AMBER, AMBER, 1, F_ONEHOT, 1));
    drive(304, 1'b0, V(RED, RED, 0, DARK, DARK, 1, F_ONEHOT, 1));

    if (sb.size() != 0) begin
      n_run++;
      n_fail++;
      $display("FAIL scoreboard_leftover: got %0d entries, want 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_lamp_monitor.md
# traffic_lamp_monitor

Safety stage directly downstream of the two-road traffic controller. It consumes the controller's `light_A`/`light_B` codes and drives the registered lamp outputs. It also checks every cycle for illegal encodings, conflicting greens, illegal sequences and short all-red clearance. On any violation it latches a fault, flashes amber on both roads, and recovers only after an operator clear followed by a verified all-red interval.

## Interface
- `BLINK_HALF`, 1: cycles per half-period of the fault amber flash (≥1).
- `MIN_ALLRED`, 2: minimum consecutive all-red input cycles required before either road turns green (≥1).
- `RECOVER_CYC`, 2: consecutive clean all-red input cycles required in RECOVER before returning to NORMAL (≥1).
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `light_A` in 3: controller code for road A, {red,amber,green} = bits {2,1,0}.
- `light_B` in 3: controller code for road B, same encoding.
- `clear_fault` in 1: operator clear, level-sampled.
- `lamp_A` out 3: registered lamp drive for road A, same encoding.
- `lamp_B` out 3: registered lamp drive for road B.
- `fault` out 1: high in FAULT and RECOVER.
- `fault_code` out 3: first-fault code, held until NORMAL is re-entered.
- `fault_count` out 8: saturating count of NORMAL→FAULT entries.

## Operation
- Legal codes are RED=100, AMBER=010 and GREEN=001. Any other value is non-one-hot.
- Fault checks are evaluated on the current inputs against `prev_A`/`prev_B` (the inputs registered the previous cycle). Priority order, first match wins:
  - 1: either input non-one-hot.
  - 2: both inputs non-red.
  - 3: illegal per-road transition. Legal transitions are G→G, G→A, A→A, A→R, R→R and R→G; all others are illegal. A transition from a non-one-hot previous value is not checked.
  - 4: a road goes R→G while `allred_cnt < MIN_ALLRED`.
- `allred_cnt` counts consecutive past cycles with both inputs red, saturating at `MIN_ALLRED`. It clears on any cycle that is not all-red.
- FSM states:
  - NORMAL: lamps = inputs. A fault moves to FAULT, latches `fault_code`, and increments `fault_count` (saturates at 255).
  - FAULT: both lamps = AMBER during the ON phase and 000 during the OFF phase. The phase toggles every `BLINK_HALF` cycles, starting ON. Further violations do not overwrite the code. Moves to RECOVER when `clear_fault`=1 and both inputs are RED in the same cycle; otherwise stays.
  - RECOVER: both lamps RED solid. Counts consecutive cycles with both inputs RED and no fault. Reaching `RECOVER_CYC` moves to NORMAL and clears `fault_code`. Any non-red input or any fault returns to FAULT with the code unchanged, `fault_count` not incremented, and the blink restarting ON.
- `clear_fault` is ignored outside FAULT.
- `prev_*` and `allred_cnt` track the inputs in all states.

## Timing
- Reset values:
  - `lamp_A` = `lamp_B` = 100, `fault` = 0, `fault_code` = 0, `fault_count` = 0.
  - State NORMAL.
  - `prev_A` = `prev_B` = RED, `allred_cnt` = `MIN_ALLRED`, so a green in the first cycle after reset is legal.
  - Blink counter 0, phase ON.
- Latency: one cycle, input at edge n → lamps at edge n+1.
- A violation sampled at edge n gives `fault`=1, `fault_code` and flashing amber ON, all visible after edge n; the cycle-n inputs are never passed through.
- Exit from RECOVER: NORMAL pass-through begins on the cycle after the `RECOVER_CYC`-th clean sample. `fault` falls at that same edge.
- Simultaneous events:
  - A fault and `clear_fault` in the same FAULT cycle: the clear is accepted only if both inputs are red.
  - `reset` overrides everything at the next edge, including mid-FAULT and mid-RECOVER.

## Structure
- `traffic_pkg` holds:
  - light encodings RED/AMBER/GREEN,
  - fault code constants F_NONE=0, F_ONEHOT=1, F_CONFLICT=2, F_SEQ=3, F_ALLRED=4,
  - the state enum NORMAL/FAULT/RECOVER.
- One sub-module, `lamp_blinker`: parameterised by `BLINK_HALF`, with inputs `restart`/`enable` and output `phase_on`.
- Checker logic, the FSM and counters live in `traffic_lamp_monitor`.

## Test plan
- Nominal controller sequence (A: G×7, A×2, R…; B red; 2-cycle all-red gaps) for 3 full cycles → lamps equal the inputs delayed 1 cycle, `fault` stays 0.
- `light_A`=001 and `light_B`=001 for one cycle → next edge: `fault`=1, `fault_code`=2, lamps 010/010. With `BLINK_HALF`=1, lamps alternate 010 and 000 every cycle. `fault_count`=1.
- A goes G→R directly → `fault_code`=3. Then drive both red, pulse `clear_fault`, and hold red for 2 cycles → lamps 100/100 during RECOVER, then pass-through, with `fault`=0 and `fault_code`=0.
- Only 1 all-red cycle, then B goes R→G (`MIN_ALLRED`=2) → `fault_code`=4.
- In RECOVER, raise `light_B`=001 → back to FAULT, `fault_code` unchanged, `fault_count` unchanged, blink restarts ON.
- Assert `reset` mid-FAULT → next edge: lamps 100/100, `fault`=0, `fault_count`=0, NORMAL. An immediate green on A is accepted without fault.
